// File: rtl/ddram_byte_port.sv
// Byte-wide DMA responder with a one-line read cache, mapped onto single-beat 64-bit DDRAM accesses.
// Build option: define DDRB_STATS_EN to add saturating hit/miss counters (O_HITS, O_MISSES).
module ddram_byte_port #(
    parameter logic [3:0] BASE_NIBBLE = 4'h3
) (
    input  logic        I_CLK,
    input  logic        I_RSTn,
    input  logic [27:0] I_ADDR,
    input  logic        I_RD,
    input  logic        I_WE,
    input  logic [7:0]  I_DIN,
    output logic [7:0]  O_DOUT,
    output logic        O_READY,
`ifdef DDRB_STATS_EN
    output logic [15:0] O_HITS,
    output logic [15:0] O_MISSES,
`endif
    output logic [2:0]  O_DBG_STATE,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    // Request side: I_RD/I_WE are sampled only on an edge where O_READY=1 (state IDLE);
    // anything presented while O_READY=0 is dropped. DDR side: a command is held until
    // an edge with DDRAM_BUSY=0; a read beat counts only when DDRAM_DOUT_READY=1 in RD_WAIT.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HIT     = 3'd1,
        S_RD_CMD  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_CMD  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] line_q;
    logic [24:0] tag_q;
    logic        valid_q;
    logic [2:0]  ofs_q;
    logic [7:0]  dout_q;
    logic [28:0] ddr_addr_q;
    logic [7:0]  be_q;
    logic [63:0] din_q;
    logic        cache_hit;
    logic        wr_line_cached;
    logic        accept;

    assign cache_hit      = valid_q && (tag_q == I_ADDR[27:3]);
    assign wr_line_cached = valid_q && (tag_q == ddr_addr_q[24:0]);
    assign accept         = (state_q == S_IDLE) && (I_RD || I_WE);

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        O_READY  = 1'b0;
        DDRAM_RD = 1'b0;
        DDRAM_WE = 1'b0;
        case (state_q)
            S_IDLE: begin
                O_READY = 1'b1;
                // A write presented together with a read wins; the read is discarded.
                if (I_WE)      state_d = S_WR_CMD;
                else if (I_RD) state_d = cache_hit ? S_HIT : S_RD_CMD;
            end
            S_HIT: state_d = S_IDLE;
            S_RD_CMD: begin
                DDRAM_RD = 1'b1;
                if (!DDRAM_BUSY) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: if (DDRAM_DOUT_READY) state_d = S_IDLE;
            S_WR_CMD: begin
                DDRAM_WE = 1'b1;
                if (!DDRAM_BUSY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            line_q     <= '0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            ofs_q      <= '0;
            dout_q     <= '0;
            ddr_addr_q <= '0;
            be_q       <= '0;
            din_q      <= '0;
        end else begin
            if (accept) begin
                ofs_q      <= I_ADDR[2:0];
                ddr_addr_q <= {BASE_NIBBLE, I_ADDR[27:3]};
                be_q       <= 8'b1 << I_ADDR[2:0];
                din_q      <= {8{I_DIN}};
            end
            if (state_q == S_HIT) dout_q <= line_q[{ofs_q, 3'b000} +: 8];
            if (state_q == S_RD_WAIT && DDRAM_DOUT_READY) begin
                line_q  <= DDRAM_DOUT;
                tag_q   <= ddr_addr_q[24:0];
                valid_q <= 1'b1;
                dout_q  <= DDRAM_DOUT[{ofs_q, 3'b000} +: 8];
            end
            // Write-through keeps the cached line coherent with DDR.
            if (state_q == S_WR_CMD && !DDRAM_BUSY && wr_line_cached)
                line_q[{ofs_q, 3'b000} +: 8] <= din_q[7:0];
        end
    end

`ifdef DDRB_STATS_EN
    logic [15:0] hits_q, misses_q;

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == S_IDLE && I_RD && !I_WE) begin
            if (cache_hit && hits_q != 16'hFFFF)    hits_q   <= hits_q + 16'd1;
            if (!cache_hit && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
        end
    end

    assign O_HITS   = hits_q;
    assign O_MISSES = misses_q;
`endif

    assign O_DOUT         = dout_q;
    assign O_DBG_STATE    = state_q;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = ddr_addr_q;
    assign DDRAM_BE       = be_q;
    assign DDRAM_DIN      = din_q;

endmodule

// File: tb/tb_ddram_byte_port.sv
// Self-checking bench for ddram_byte_port: directed scenarios plus randomized traffic against a byte-level memory/cache model.
module tb_ddram_byte_port;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [27:0] I_ADDR;
  logic        I_RD, I_WE;
  logic [7:0]  I_DIN;
  logic [7:0]  O_DOUT;
  logic        O_READY;
  logic [2:0]  O_DBG_STATE;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
`ifdef DDRB_STATS_EN
  logic [15:0] O_HITS, O_MISSES;
`endif

  ddram_byte_port dut (
    .I_CLK(clk_sys), .I_RSTn(rst_n), .I_ADDR(I_ADDR), .I_RD(I_RD), .I_WE(I_WE),
    .I_DIN(I_DIN), .O_DOUT(O_DOUT), .O_READY(O_READY),
`ifdef DDRB_STATS_EN
    .O_HITS(O_HITS), .O_MISSES(O_MISSES),
`endif
    .O_DBG_STATE(O_DBG_STATE), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  int both_err = 0;

  // DDR contents as seen on the bus, and the intended contents from the requester's view.
  logic [7:0]  ddr_b [int unsigned];
  logic [7:0]  ref_b [int unsigned];
  logic        ref_valid;
  logic [24:0] ref_line;
  logic [7:0]  exp_dout;
  int          exp_hits, exp_misses;
  logic [28:0] last_rd_addr;
  logic [7:0]  last_be;
  logic [63:0] last_din;
  logic [7:0]  exp_q[$];

  function automatic int unsigned key(logic [27:0] a);
    return {4'b0, a};
  endfunction

  function automatic logic [7:0] dflt(logic [27:0] a);
    return a[7:0] ^ a[19:12];
  endfunction

  function automatic logic [7:0] ref_byte(logic [27:0] a);
    return ref_b.exists(key(a)) ? ref_b[key(a)] : dflt(a);
  endfunction

  function automatic logic [63:0] ddr_line(logic [24:0] line);
    logic [63:0] l;
    logic [27:0] a;
    for (int i = 0; i < 8; i++) begin
      a = {line, 3'(i)};
      l[8*i +: 8] = ddr_b.exists(key(a)) ? ddr_b[key(a)] : dflt(a);
    end
    return l;
  endfunction

  task automatic ddr_write(input logic [24:0] line, input logic [7:0] be, input logic [63:0] din);
    for (int i = 0; i < 8; i++)
      if (be[i]) ddr_b[key({line, 3'(i)})] = din[8*i +: 8];
  endtask

  task automatic model_reset();
    ref_valid  = 1'b0;
    exp_dout   = 8'h00;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One request through the port, with the bench acting as the DDR controller.
  task automatic do_req(input logic rd, input logic we, input logic [27:0] addr,
                        input logic [7:0] din, input int busy,
                        output logic [7:0] dout, output int n_rd, output int n_wr,
                        output int edges, output int cmd_cycles, output logic ok,
                        output int exp_nrd, output logic [7:0] exp_byte);
    int          busy_left;
    logic        beat_pending;
    logic [24:0] rd_line;
    logic        is_rd;
    busy_left = busy; beat_pending = 1'b0; rd_line = '0;
    n_rd = 0; n_wr = 0; edges = 0; cmd_cycles = 0; ok = 1'b0;
    is_rd = rd && !we;
    exp_nrd = (is_rd && !(ref_valid && ref_line == addr[27:3])) ? 1 : 0;
    if (we) ref_b[key(addr)] = din;
    if (is_rd) begin
      exp_dout = ref_byte(addr);
      if (exp_nrd == 1) begin ref_valid = 1'b1; ref_line = addr[27:3]; exp_misses++; end
      else exp_hits++;
    end
    exp_byte = exp_dout;

    @(negedge clk_sys);
    I_ADDR = addr; I_RD = rd; I_WE = we; I_DIN = din; DDRAM_BUSY = 1'b0;
    while (edges < 100) begin
      @(posedge clk_sys);
      edges++;
      @(negedge clk_sys);
      I_RD = 1'b0; I_WE = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_BUSY = 1'b0;
      if (O_READY) begin ok = 1'b1; break; end
      if (DDRAM_RD && DDRAM_WE) both_err++;
      if (DDRAM_RD || DDRAM_WE) begin
        cmd_cycles++;
        if (busy_left > 0) begin
          DDRAM_BUSY = 1'b1; busy_left--;
        end else if (DDRAM_RD) begin
          n_rd++; rd_line = DDRAM_ADDR[24:0]; last_rd_addr = DDRAM_ADDR; beat_pending = 1'b1;
        end else begin
          n_wr++; last_be = DDRAM_BE; last_din = DDRAM_DIN;
          ddr_write(DDRAM_ADDR[24:0], DDRAM_BE, DDRAM_DIN);
        end
      end else if (beat_pending) begin
        DDRAM_DOUT = ddr_line(rd_line); DDRAM_DOUT_READY = 1'b1; beat_pending = 1'b0;
      end
    end
    dout = O_DOUT;
  endtask

  task automatic test_reset();
    logic [7:0] dout, eb; int nr, nw, ed, cc, en; logic ok;
    rst_n = 1'b0; I_ADDR = '0; I_RD = 1'b0; I_WE = 1'b0; I_DIN = '0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys); rst_n = 1'b1;
    @(negedge clk_sys);
    checks++; if (O_READY !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b exp 1", O_READY); end
    checks++; if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0) begin failures++; $display("FAIL rst_cmds: rd=%b we=%b exp 0 0", DDRAM_RD, DDRAM_WE); end
    checks++; if (DDRAM_ADDR !== 29'h0 || DDRAM_BE !== 8'h0 || DDRAM_DIN !== 64'h0) begin failures++; $display("FAIL rst_bus: addr=%h be=%h din=%h exp zeros", DDRAM_ADDR, DDRAM_BE, DDRAM_DIN); end
    checks++; if (O_DOUT !== 8'h00) begin failures++; $display("FAIL rst_dout: got %h exp 00", O_DOUT); end
    checks++; if (O_DBG_STATE !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d exp 0", O_DBG_STATE); end
    checks++; if (DDRAM_BURSTCNT !== 8'd1) begin failures++; $display("FAIL burstcnt: got %0d exp 1", DDRAM_BURSTCNT); end
    do_req(1'b1, 1'b0, 28'h10, 8'h00, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (!ok || nr !== 1) begin failures++; $display("FAIL first_rd_miss: ok=%b rd_cmds=%0d exp 1", ok, nr); end
    checks++; if (last_rd_addr !== {4'h3, 25'h2}) begin failures++; $display("FAIL first_rd_addr: got %h exp %h", last_rd_addr, {4'h3, 25'h2}); end
    checks++; if (dout !== 8'h10) begin failures++; $display("FAIL first_rd_data: got %h exp 10", dout); end
  endtask

  task automatic test_write_read();
    logic [7:0] dout, eb; int nr, nw, ed, cc, en; logic ok;
    do_req(1'b0, 1'b1, 28'h3, 8'h55, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (!ok || nw !== 1 || nr !== 0 || cc !== 1 || ed !== 2) begin failures++; $display("FAIL wr_cmd: ok=%b wr=%0d rd=%0d we_cycles=%0d edges=%0d exp 1 1 0 1 2", ok, nw, nr, cc, ed); end
    checks++; if (last_be !== 8'h08) begin failures++; $display("FAIL wr_be: got %h exp 08", last_be); end
    checks++; if (last_din !== 64'h5555555555555555) begin failures++; $display("FAIL wr_din: got %h exp 5555555555555555", last_din); end
    checks++; if (dout !== eb) begin failures++; $display("FAIL wr_dout_kept: got %h exp %h", dout, eb); end
    do_req(1'b1, 1'b0, 28'h3, 8'h00, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (!ok || nr !== 1 || dout !== 8'h55) begin failures++; $display("FAIL wr_readback: ok=%b rd=%0d data=%h exp 1 55", ok, nr, dout); end
  endtask

  task automatic test_sequential();
    logic [7:0] dout, eb; int nr, nw, ed, cc, en; logic ok; int total_rd;
    total_rd = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, 1'b0, 28'h8 + 28'(i), 8'h00, 0, dout, nr, nw, ed, cc, ok, en, eb);
      total_rd += nr;
      checks++; if (!ok || dout !== 8'(8 + i)) begin failures++; $display("FAIL seq_data[%0d]: ok=%b got %h exp %h", i, ok, dout, 8'(8 + i)); end
      if (i > 0) begin
        checks++; if (ed !== 2) begin failures++; $display("FAIL seq_hit_latency[%0d]: got %0d exp 2", i, ed); end
      end
    end
    checks++; if (total_rd !== 1) begin failures++; $display("FAIL seq_one_fetch: got %0d exp 1", total_rd); end
    do_req(1'b1, 1'b0, 28'h10, 8'h00, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (nr !== 1 || last_rd_addr !== {4'h3, 25'h2}) begin failures++; $display("FAIL seq_next_line: rd=%0d addr=%h exp 1 %h", nr, last_rd_addr, {4'h3, 25'h2}); end
  endtask

  task automatic test_busy();
    logic [7:0] dout, eb; int nr, nw, ed, cc, en; logic ok;
    do_req(1'b1, 1'b0, 28'h1A5, 8'h00, 5, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (cc !== 6 || nr !== 1) begin failures++; $display("FAIL busy_rd_hold: rd_high=%0d fetches=%0d exp 6 1", cc, nr); end
    checks++; if (!ok || ed !== 8) begin failures++; $display("FAIL busy_latency: ok=%b edges=%0d exp 8", ok, ed); end
    checks++; if (dout !== 8'hA5 || last_rd_addr !== {4'h3, 25'h34}) begin failures++; $display("FAIL busy_data: data=%h addr=%h exp a5 %h", dout, last_rd_addr, {4'h3, 25'h34}); end
  endtask

  task automatic test_rd_we();
    logic [7:0] dout, eb; int nr, nw, ed, cc, en; logic ok;
    do_req(1'b1, 1'b0, 28'h20, 8'h00, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (dout !== 8'h20) begin failures++; $display("FAIL rdwe_prime: got %h exp 20", dout); end
    do_req(1'b1, 1'b1, 28'h20, 8'hAA, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (!ok || nr !== 0 || nw !== 1) begin failures++; $display("FAIL rdwe_write_wins: ok=%b rd=%0d wr=%0d exp 0 1", ok, nr, nw); end
    checks++; if (last_be !== 8'h01 || last_din !== {8{8'hAA}} || dout !== 8'h20) begin failures++; $display("FAIL rdwe_bus: be=%h din=%h dout=%h exp 01 aa.. 20", last_be, last_din, dout); end
    do_req(1'b1, 1'b0, 28'h20, 8'h00, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (nr !== 0 || dout !== 8'hAA || ed !== 2) begin failures++; $display("FAIL rdwe_writethrough: rd=%0d data=%h edges=%0d exp 0 aa 2", nr, dout, ed); end
  endtask

  task automatic test_random();
    logic [7:0] dout, eb, din, exp_rd; int nr, nw, ed, cc, en; logic ok;
    logic rd, we; logic [27:0] addr; int kind;
    for (int n = 0; n < 80; n++) begin
      addr = 28'($urandom_range(0, 63));
      kind = $urandom_range(0, 3);
      we = (kind == 0 || kind == 3);
      rd = (kind != 0);
      din = 8'($urandom);
      do_req(rd, we, addr, din, $urandom_range(0, 2), dout, nr, nw, ed, cc, ok, en, eb);
      checks++; if (!ok) begin failures++; $display("FAIL rand_timeout[%0d]: O_READY never returned", n); end
      checks++; if (nr !== en || nw !== int'(we)) begin failures++; $display("FAIL rand_cmds[%0d]: rd=%0d wr=%0d exp %0d %0d", n, nr, nw, en, int'(we)); end
      if (rd && !we) exp_q.push_back(eb);
      if (exp_q.size() > 0) begin
        exp_rd = exp_q.pop_front();
        checks++; if (dout !== exp_rd) begin failures++; $display("FAIL rand_rd_data[%0d]: addr=%h got %h exp %h", n, addr, dout, exp_rd); end
      end else begin
        checks++; if (dout !== eb) begin failures++; $display("FAIL rand_dout_kept[%0d]: got %h exp %h", n, dout, eb); end
      end
    end
    checks++; if (both_err !== 0) begin failures++; $display("FAIL rd_we_overlap: got %0d cycles exp 0", both_err); end
`ifdef DDRB_STATS_EN
    checks++; if (O_HITS !== 16'(exp_hits) || O_MISSES !== 16'(exp_misses)) begin failures++; $display("FAIL stats: hits=%0d misses=%0d exp %0d %0d", O_HITS, O_MISSES, exp_hits, exp_misses); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] dout, eb; int nr, nw, ed, cc, en; logic ok;
    @(negedge clk_sys);
    I_ADDR = 28'h40; I_RD = 1'b1; DDRAM_BUSY = 1'b0;
    @(posedge clk_sys); @(negedge clk_sys);
    I_RD = 1'b0;
    @(posedge clk_sys); @(negedge clk_sys);
    checks++; if (O_DBG_STATE !== 3'd3 || O_READY !== 1'b0) begin failures++; $display("FAIL mid_in_wait: state=%0d ready=%b exp 3 0", O_DBG_STATE, O_READY); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (O_READY !== 1'b1 || O_DBG_STATE !== 3'd0 || DDRAM_ADDR !== 29'h0) begin failures++; $display("FAIL mid_async_rst: ready=%b state=%0d addr=%h exp 1 0 0", O_READY, O_DBG_STATE, DDRAM_ADDR); end
    @(negedge clk_sys);
    rst_n = 1'b1;
    model_reset();
    DDRAM_DOUT = 64'hDEADBEEF01234567; DDRAM_DOUT_READY = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    checks++; if (O_DOUT !== 8'h00 || O_READY !== 1'b1 || O_DBG_STATE !== 3'd0 || DDRAM_RD !== 1'b0) begin failures++; $display("FAIL mid_beat_ignored: dout=%h ready=%b state=%0d rd=%b exp 00 1 0 0", O_DOUT, O_READY, O_DBG_STATE, DDRAM_RD); end
`ifdef DDRB_STATS_EN
    checks++; if (O_HITS !== 16'd0 || O_MISSES !== 16'd0) begin failures++; $display("FAIL mid_stats_clr: hits=%0d misses=%0d exp 0 0", O_HITS, O_MISSES); end
`endif
    do_req(1'b1, 1'b0, 28'h40, 8'h00, 0, dout, nr, nw, ed, cc, ok, en, eb);
    checks++; if (nr !== 1 || dout !== 8'h40) begin failures++; $display("FAIL mid_cache_invalid: rd=%0d data=%h exp 1 40", nr, dout); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_sequential();
    test_busy();
    test_rd_we();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
